// File: rtl/rf_tx_framer_pkg.sv
// Shared definitions for the RF transmit framer: FSM encoding, framing bytes
// and the byte-wise CRC-16 (reflected 0x8408) update step.
package rf_tx_framer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRE    = 3'd1,
    ST_SYNC   = 3'd2,
    ST_LEN    = 3'd3,
    ST_PLD    = 3'd4,
    ST_CRC_LO = 3'd5,
    ST_CRC_HI = 3'd6
  } rf_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [15:0] CRC_INIT      = 16'hFFFF;
  localparam logic [15:0] CRC_POLY_REFL = 16'h8408;

  // One byte through the LSB-first CRC register.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc,
                                             input logic [7:0]  din);
    logic [15:0] c;
    c = crc ^ {8'h00, din};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/rf_tx_framer_crc.sv
// Byte-wise CRC-16 engine: init FFFF, reflected poly 0x8408, inverted output.
// Register updates one byte per enabled cycle; dout_o reflects all prior bytes.
module crc_logic_rf
  import rf_tx_framer_pkg::*;
(
  input  logic        clk_i,
  input  logic        nrst_i,
  input  logic        syn_rst_i,
  input  logic        en_i,
  input  logic [7:0]  din_i,
  output logic [15:0] dout_o
);

  logic [15:0] crc_q;

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      crc_q <= CRC_INIT;
    end else if (syn_rst_i) begin
      crc_q <= CRC_INIT;
    end else if (en_i) begin
      crc_q <= crc16_byte(crc_q, din_i);
    end
  end

  assign dout_o = ~crc_q;

endmodule

// File: rtl/rf_tx_framer.sv
// RF transmit framer: preamble, sync word, length, payload and CRC-16 (low byte
// first) through a one-entry registered output slot.
module rf_tx_framer
  import rf_tx_framer_pkg::*;
#(
  parameter int unsigned PREAMBLE_LEN = 4,
  parameter logic [15:0] SYNC_WORD    = 16'h2DD4,
  parameter bit          CRC_INCL_LEN = 1'b1
) (
  input  logic       clk_i,
  input  logic       nrst_i,
  input  logic       start_i,
  input  logic [7:0] len_i,
  input  logic       abort_i,
  input  logic [7:0] pld_data_i,
  input  logic       pld_valid_i,
  output logic       pld_ready_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output logic       busy_o,
  output logic       done_o,
  output rf_state_e  state_o
);

  localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_LEN - 1);

  rf_state_e   state_q, state_d;
  logic [3:0]  hdr_cnt_q;
  logic [7:0]  pld_cnt_q;
  logic [7:0]  len_q;
  logic        crc_hi_sent_q;
  logic [7:0]  tx_data_q;
  logic        tx_valid_q;

  logic        slot_free;
  logic        load;
  logic [7:0]  load_byte;
  logic        crc_en;
  logic        crc_syn_rst;
  logic [15:0] crc_dout;

  // Handshakes: a byte moves on any rising edge where valid & ready are both
  // high; the output slot refills in the same cycle its byte is taken.
  assign slot_free = ~tx_valid_q | tx_ready_i;

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (start_i) state_d = ST_PRE;
        ST_PRE:    if (load && hdr_cnt_q == PRE_LAST) state_d = ST_SYNC;
        ST_SYNC:   if (load && hdr_cnt_q[0]) state_d = ST_LEN;
        ST_LEN:    if (load) state_d = (len_q == 8'd0) ? ST_CRC_LO : ST_PLD;
        ST_PLD:    if (load && pld_cnt_q == 8'd1) state_d = ST_CRC_LO;
        ST_CRC_LO: if (load) state_d = ST_CRC_HI;
        ST_CRC_HI: if (done_o) state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    load        = 1'b0;
    load_byte   = 8'h00;
    crc_en      = 1'b0;
    pld_ready_o = 1'b0;
    done_o      = 1'b0;
    crc_syn_rst = abort_i | ((state_q == ST_IDLE) & start_i);
    if (!abort_i) begin
      case (state_q)
        ST_PRE: begin
          load      = slot_free;
          load_byte = PREAMBLE_BYTE;
        end
        ST_SYNC: begin
          load      = slot_free;
          load_byte = hdr_cnt_q[0] ? SYNC_WORD[7:0] : SYNC_WORD[15:8];
        end
        ST_LEN: begin
          load      = slot_free;
          load_byte = len_q;
          crc_en    = slot_free & CRC_INCL_LEN;
        end
        ST_PLD: begin
          pld_ready_o = slot_free;
          load        = slot_free & pld_valid_i;
          load_byte   = pld_data_i;
          crc_en      = slot_free & pld_valid_i;
        end
        ST_CRC_LO: begin
          load      = slot_free;
          load_byte = crc_dout[7:0];
        end
        ST_CRC_HI: begin
          // Load the high byte once, then wait for it to leave the slot.
          if (!crc_hi_sent_q) begin
            load      = slot_free;
            load_byte = crc_dout[15:8];
          end else begin
            done_o = tx_valid_q & tx_ready_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      hdr_cnt_q     <= 4'd0;
      pld_cnt_q     <= 8'd0;
      len_q         <= 8'd0;
      crc_hi_sent_q <= 1'b0;
    end else if (abort_i) begin
      hdr_cnt_q     <= 4'd0;
      pld_cnt_q     <= 8'd0;
      crc_hi_sent_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && start_i) begin
        len_q <= len_i;
      end
      if (state_d != state_q) begin
        hdr_cnt_q <= 4'd0;
      end else if (load && (state_q == ST_PRE || state_q == ST_SYNC)) begin
        hdr_cnt_q <= hdr_cnt_q + 4'd1;
      end
      if (state_q == ST_LEN && load) begin
        pld_cnt_q <= len_q;
      end else if (state_q == ST_PLD && load) begin
        pld_cnt_q <= pld_cnt_q - 8'd1;
      end
      if (state_q == ST_CRC_HI && load) begin
        crc_hi_sent_q <= 1'b1;
      end else if (state_d != state_q) begin
        crc_hi_sent_q <= 1'b0;
      end
    end
  end

  // An abort drops whatever is pending in the slot.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else if (abort_i) begin
      tx_valid_q <= 1'b0;
    end else if (slot_free) begin
      tx_valid_q <= load;
      if (load) begin
        tx_data_q <= load_byte;
      end
    end
  end

  crc_logic_rf u_crc (
    .clk_i     (clk_i),
    .nrst_i    (nrst_i),
    .syn_rst_i (crc_syn_rst),
    .en_i      (crc_en),
    .din_i     (load_byte),
    .dout_o    (crc_dout)
  );

  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign state_o    = state_q;

endmodule

// File: tb/tb_rf_tx_framer.sv
// Bench for rf_tx_framer: two instances (CRC over payload only / over length +
// payload) share stimulus; each has its own expected-byte queue.
module tb_rf_tx_framer;
  import rf_tx_framer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  logic       start, abort, pld_valid, tx_ready;
  logic [7:0] len_in, pld_data;
  logic       pld_ready_w [2];
  logic       tx_valid_w  [2];
  logic       busy_w      [2];
  logic       done_w      [2];
  logic [7:0] tx_data_w   [2];
  rf_state_e  state_w     [2];

  rf_tx_framer #(.PREAMBLE_LEN(4), .SYNC_WORD(16'h2DD4), .CRC_INCL_LEN(1'b0)) u_dut_pld (
    .clk_i(clk), .nrst_i(nrst), .start_i(start), .len_i(len_in), .abort_i(abort),
    .pld_data_i(pld_data), .pld_valid_i(pld_valid), .pld_ready_o(pld_ready_w[0]),
    .tx_data_o(tx_data_w[0]), .tx_valid_o(tx_valid_w[0]), .tx_ready_i(tx_ready),
    .busy_o(busy_w[0]), .done_o(done_w[0]), .state_o(state_w[0])
  );

  rf_tx_framer #(.PREAMBLE_LEN(4), .SYNC_WORD(16'h2DD4), .CRC_INCL_LEN(1'b1)) u_dut_len (
    .clk_i(clk), .nrst_i(nrst), .start_i(start), .len_i(len_in), .abort_i(abort),
    .pld_data_i(pld_data), .pld_valid_i(pld_valid), .pld_ready_o(pld_ready_w[1]),
    .tx_data_o(tx_data_w[1]), .tx_valid_o(tx_valid_w[1]), .tx_ready_i(tx_ready),
    .busy_o(busy_w[1]), .done_o(done_w[1]), .state_o(state_w[1])
  );

  // ---------------- scoreboard state ----------------
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  logic [7:0] pay [256];
  int         rx_cnt   [2] = '{0, 0};
  int         done_cnt [2] = '{0, 0};
  bit         saw_pld  [2] = '{0, 0};
  logic       prev_hold[2] = '{1'b0, 1'b0};
  logic [7:0] prev_data[2] = '{8'h00, 8'h00};
  logic       prev_abort = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ b[i];
      r  = {1'b0, r[15:1]};
      if (fb) r = r ^ 16'h8408;
    end
    return r;
  endfunction

  task automatic push2(input bit m0, input bit m1, input logic [7:0] b0, input logic [7:0] b1);
    if (m0) exp_q0.push_back(b0);
    if (m1) exp_q1.push_back(b1);
  endtask

  task automatic push_hdr(input int len);
    logic [7:0] l;
    l = 8'(len);
    for (int i = 0; i < 4; i++) push2(1, 1, 8'h55, 8'h55);
    push2(1, 1, 8'h2D, 8'h2D);
    push2(1, 1, 8'hD4, 8'hD4);
    push2(1, 1, l, l);
  endtask

  task automatic push_frame(input int len, input bit m0, input bit m1);
    logic [15:0] c0, c1;
    logic [7:0]  l;
    l  = 8'(len);
    c0 = 16'hFFFF;
    c1 = crc_upd(16'hFFFF, l);
    for (int i = 0; i < 4; i++) push2(m0, m1, 8'h55, 8'h55);
    push2(m0, m1, 8'h2D, 8'h2D);
    push2(m0, m1, 8'hD4, 8'hD4);
    push2(m0, m1, l, l);
    for (int i = 0; i < len; i++) begin
      push2(m0, m1, pay[i], pay[i]);
      c0 = crc_upd(c0, pay[i]);
      c1 = crc_upd(c1, pay[i]);
    end
    c0 = ~c0;
    c1 = ~c1;
    push2(m0, m1, c0[7:0], c1[7:0]);
    push2(m0, m1, c0[15:8], c1[15:8]);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [7:0] exp_b;
    for (int d = 0; d < 2; d++) begin
      if (!nrst) begin
        prev_hold[d] = 1'b0;
      end else begin
        if (prev_hold[d] && !prev_abort) begin
          check("hold_valid", 32'(tx_valid_w[d]), 32'd1);
          check("hold_data", 32'(tx_data_w[d]), 32'(prev_data[d]));
        end
        if (state_w[d] == ST_PLD) saw_pld[d] = 1'b1;
        if (pld_valid && state_w[d] != ST_PLD)
          check("pld_ready_outside_pld", 32'(pld_ready_w[d]), 32'd0);
        if (done_w[d]) done_cnt[d]++;
        if (tx_valid_w[d] && tx_ready) begin
          rx_cnt[d]++;
          if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
            n_vec++;
            n_err++;
            $display("FAIL extra_byte dut%0d: got %0h, expected none (t=%0t)", d, tx_data_w[d], $time);
          end else begin
            exp_b = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check(d == 0 ? "byte_dut_pld" : "byte_dut_len", 32'(tx_data_w[d]), 32'(exp_b));
          end
        end
        prev_hold[d] = tx_valid_w[d] & ~tx_ready;
        prev_data[d] = tx_data_w[d];
      end
    end
    prev_abort = abort;
  end

  // ---------------- driver tasks ----------------
  task automatic check_idle_outputs(input string name);
    for (int d = 0; d < 2; d++) begin
      check({name, "_tx_valid"}, 32'(tx_valid_w[d]), 32'd0);
      check({name, "_tx_data"}, 32'(tx_data_w[d]), 32'd0);
      check({name, "_busy"}, 32'(busy_w[d]), 32'd0);
      check({name, "_done"}, 32'(done_w[d]), 32'd0);
      check({name, "_pld_ready"}, 32'(pld_ready_w[d]), 32'd0);
      check({name, "_state"}, 32'(state_w[d]), 32'(ST_IDLE));
    end
  endtask

  task automatic run_frame(input int len, input bit stall, input int abort_at,
                           input bit busy_start, input bit rst_in_sync, output bit done_seen);
    int budget, cycles, idx;
    bit fin, accept;
    budget    = 8 * (len + 16) + 100;
    cycles    = 0;
    idx       = 0;
    fin       = 0;
    done_seen = 0;
    @(posedge clk); #1;
    start  = 1'b1;
    len_in = 8'(len);
    @(posedge clk); #1;
    start = 1'b0;
    while (!fin && cycles < budget) begin
      tx_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (idx < len) begin
        pld_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        pld_data  = pay[idx];
      end else begin
        pld_valid = 1'b1;
        pld_data  = 8'hEE;
      end
      abort = (abort_at >= 0 && idx == abort_at);
      if (busy_start && cycles >= 1) begin
        start  = 1'b1;
        len_in = 8'd7;
      end
      @(negedge clk);
      accept = pld_valid && pld_ready_w[0];
      if (done_w[0]) begin
        done_seen = 1;
        fin       = 1;
      end
      if (rst_in_sync && state_w[0] == ST_SYNC) begin
        nrst = 1'b0;
        #1;
        check_idle_outputs("reset_mid_frame");
        fin = 1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (accept) idx++;
      if (abort) fin = 1;
      cycles++;
    end
    start     = 1'b0;
    abort     = 1'b0;
    pld_valid = 1'b0;
    tx_ready  = 1'b1;
    if (!fin) begin
      n_vec++;
      n_err++;
      $display("FAIL frame_timeout: got no done after %0d cycles, expected done (len=%0d)", budget, len);
    end
  endtask

  task automatic do_frame(input int len, input bit stall, input bit busy_start,
                          input int exp_bytes, input bit push_q0);
    int rx_b[2], dn_b[2];
    bit ds;
    for (int d = 0; d < 2; d++) begin
      rx_b[d]    = rx_cnt[d];
      dn_b[d]    = done_cnt[d];
      saw_pld[d] = 1'b0;
    end
    push_frame(len, push_q0, 1'b1);
    run_frame(len, stall, -1, busy_start, 1'b0, ds);
    check("done_seen", 32'(ds), 32'd1);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("byte_count", 32'(rx_cnt[d] - rx_b[d]), 32'(exp_bytes));
      check("done_pulses", 32'(done_cnt[d] - dn_b[d]), 32'd1);
      check("busy_after_done", 32'(busy_w[d]), 32'd0);
      check("pld_state_entered", 32'(saw_pld[d]), 32'(len != 0));
    end
    check("queue_empty_pld", 32'(exp_q0.size()), 32'd0);
    check("queue_empty_len", 32'(exp_q1.size()), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  typedef struct {
    int len;
    bit stall;
    int kind;       // 0: ascii "123..", 1: random, 2: incrementing
    int exp_bytes;
  } fvec_t;

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fvec_t vecs[6];
    logic [7:0] t1 [18];
    int rx_b[2], dn_b[2];
    bit ds;

    vecs[0] = '{len: 0,   stall: 1'b0, kind: 0, exp_bytes: 9};
    vecs[1] = '{len: 9,   stall: 1'b1, kind: 0, exp_bytes: 18};
    vecs[2] = '{len: 1,   stall: 1'b1, kind: 1, exp_bytes: 10};
    vecs[3] = '{len: 255, stall: 1'b1, kind: 1, exp_bytes: 264};
    vecs[4] = '{len: 16,  stall: 1'b0, kind: 2, exp_bytes: 25};
    vecs[5] = '{len: 2,   stall: 1'b1, kind: 2, exp_bytes: 11};

    t1 = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h2D, 8'hD4, 8'h09,
           8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
           8'h6E, 8'h90};

    nrst = 1'b0; start = 1'b0; abort = 1'b0; len_in = 8'h00;
    pld_data = 8'h00; pld_valid = 1'b0; tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset_state");
    @(posedge clk); #1;
    nrst = 1'b1;

    // Known-answer frame: CRC-16 of "123456789" without the length byte.
    for (int i = 0; i < 9; i++) pay[i] = 8'(8'h31 + i);
    for (int i = 0; i < 18; i++) exp_q0.push_back(t1[i]);
    do_frame(9, 1'b0, 1'b0, 18, 1'b0);

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 256; i++) begin
        case (vecs[v].kind)
          0:       pay[i] = 8'(8'h31 + i);
          1:       pay[i] = 8'($urandom_range(0, 255));
          default: pay[i] = 8'(i);
        endcase
      end
      do_frame(vecs[v].len, vecs[v].stall, 1'b0, vecs[v].exp_bytes, 1'b1);
    end

    // Abort while the third payload byte is offered.
    for (int i = 0; i < 9; i++) pay[i] = 8'(8'h31 + i);
    for (int d = 0; d < 2; d++) begin
      rx_b[d] = rx_cnt[d];
      dn_b[d] = done_cnt[d];
    end
    push_hdr(9);
    push2(1, 1, pay[0], pay[0]);
    push2(1, 1, pay[1], pay[1]);
    run_frame(9, 1'b0, 2, 1'b0, 1'b0, ds);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("abort_tx_valid", 32'(tx_valid_w[d]), 32'd0);
      check("abort_busy", 32'(busy_w[d]), 32'd0);
      check("abort_no_done", 32'(done_cnt[d] - dn_b[d]), 32'd0);
      check("abort_byte_count", 32'(rx_cnt[d] - rx_b[d]), 32'd9);
    end
    check("abort_queue_pld", 32'(exp_q0.size()), 32'd0);
    check("abort_queue_len", 32'(exp_q1.size()), 32'd0);
    for (int i = 0; i < 9; i++) pay[i] = 8'($urandom_range(0, 255));
    do_frame(9, 1'b0, 1'b0, 18, 1'b1);

    // start held high through a frame (different len), including the done cycle.
    for (int i = 0; i < 4; i++) pay[i] = 8'(8'hA0 + i);
    do_frame(4, 1'b0, 1'b1, 13, 1'b1);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("no_restart_busy", 32'(busy_w[d]), 32'd0);
      check("no_restart_state", 32'(state_w[d]), 32'(ST_IDLE));
    end
    for (int i = 0; i < 3; i++) pay[i] = 8'(8'hC0 + i);
    do_frame(3, 1'b0, 1'b0, 12, 1'b1);

    // Reset while the sync word is going out.
    for (int i = 0; i < 5; i++) pay[i] = 8'(8'h10 + i);
    push_frame(5, 1'b1, 1'b1);
    run_frame(5, 1'b0, -1, 1'b0, 1'b1, ds);
    exp_q0.delete();
    exp_q1.delete();
    repeat (2) @(negedge clk);
    #1;
    nrst = 1'b1;
    for (int i = 0; i < 6; i++) pay[i] = 8'($urandom_range(0, 255));
    do_frame(6, 1'b1, 1'b0, 15, 1'b1);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
